// File: rtl/mem_pkg.sv
// Shared types and helpers for the timed dual-port memory.
package mem_pkg;

    // Per-port access state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } port_state_t;

    // Width of the per-port latency counter (LATENCY up to 15).
    localparam int unsigned LAT_W = 4;

    // Drop the byte-offset bits of a byte address to get a word index.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input int unsigned off_w);
        return addr >> off_w;
    endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port access sequencer: accepts a request, counts out the access
// latency and raises a one-cycle ready once the access has completed.
module mem_port_fsm
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic accept,
    output logic fire,
    output logic ready
);

    // Count loaded when starting from IDLE: the whole latency is ahead.
    localparam logic [LAT_W-1:0] LOAD_IDLE = LAT_W'(LATENCY - 1);
    // Count loaded when chaining out of DONE: the DONE cycle already
    // counts as the first latency cycle of the next access.
    localparam logic [LAT_W-1:0] LOAD_DONE =
        (LATENCY > 1) ? LAT_W'(LATENCY - 2) : '0;

    port_state_t      state_q;
    port_state_t      state_n;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_n;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_n = BUSY;
                    cnt_n   = LOAD_IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt_q - LAT_W'(1);
                end
            end
            DONE: begin
                if (!req) begin
                    state_n = IDLE;
                end else if (LATENCY == 1) begin
                    state_n = DONE;
                end else begin
                    state_n = BUSY;
                    cnt_n   = LOAD_DONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Decoded strobes: accept on a free port, fire on the edge entering DONE.
    always_comb begin
        accept = 1'b0;
        fire   = 1'b0;
        ready  = 1'b0;
        accept = req && ((state_q == IDLE) || (state_q == DONE));
        fire   = ((state_q == BUSY) && (cnt_q == '0)) ||
                 ((state_q == DONE) && req && (LATENCY == 1));
        ready  = (state_q == DONE);
    end

endmodule

// File: rtl/timed_dual_port_mem.sv
// Two-port word memory with req/ready handshakes and configurable latency.
// Port 1 is read-only, port 2 is read/write with byte-lane enables.
// Optional build macro: MEM_RDW_FORWARD_EN -- forward a same-edge port-2
// write into a port-1 read of the same word.
module timed_dual_port_mem
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_ready,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W/8-1:0] p2_we,
    input  logic [DATA_W-1:0] p2_wdata,
    output logic [DATA_W-1:0] p2_rdata,
    output logic              p2_ready
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned IDX_W = ADDR_W - OFF_W;
    localparam int unsigned WORDS = 2 ** IDX_W;

    // Words are stored XOR-ed with their own byte address, so the all-zero
    // power-up image reads back as "each word holds its own address".
    logic [DATA_W-1:0] mem_q [WORDS];

    logic              p1_accept;
    logic              p1_fire;
    logic              p2_accept;
    logic              p2_fire;

    logic [ADDR_W-1:0] p1_addr_q;
    logic [ADDR_W-1:0] p2_addr_q;
    logic [NB-1:0]     p2_we_q;
    logic [DATA_W-1:0] p2_wdata_q;

    logic [IDX_W-1:0]  p1_idx_c;
    logic [IDX_W-1:0]  p2_idx_c;
    logic [NB-1:0]     p2_we_c;
    logic [DATA_W-1:0] p2_wdata_c;
    logic [DATA_W-1:0] p1_home_c;
    logic [DATA_W-1:0] p2_home_c;
    logic [DATA_W-1:0] p1_old_c;
    logic [DATA_W-1:0] p2_old_c;
    logic [DATA_W-1:0] p2_wenc_c;
    logic [DATA_W-1:0] p1_read_c;

    // Byte address of word idx, sized to the data word.
    function automatic logic [DATA_W-1:0] home_word(input logic [IDX_W-1:0] idx);
        return DATA_W'(ADDR_W'(idx) << OFF_W);
    endfunction

    mem_port_fsm #(
        .LATENCY (LATENCY)
    ) u_p1_fsm (
        .clk    (clk),
        .rst    (rst),
        .req    (p1_req),
        .accept (p1_accept),
        .fire   (p1_fire),
        .ready  (p1_ready)
    );

    mem_port_fsm #(
        .LATENCY (LATENCY)
    ) u_p2_fsm (
        .clk    (clk),
        .rst    (rst),
        .req    (p2_req),
        .accept (p2_accept),
        .fire   (p2_fire),
        .ready  (p2_ready)
    );

    // Capture request fields at acceptance; later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_addr_q  <= '0;
            p2_addr_q  <= '0;
            p2_we_q    <= '0;
            p2_wdata_q <= '0;
        end else begin
            if (p1_accept) begin
                p1_addr_q <= p1_addr;
            end
            if (p2_accept) begin
                p2_addr_q  <= p2_addr;
                p2_we_q    <= p2_we;
                p2_wdata_q <= p2_wdata;
            end
        end
    end

    // Effective access fields: live inputs when acceptance and completion
    // share an edge (LATENCY 1 chaining out of DONE), captured ones otherwise.
    always_comb begin
        p1_idx_c   = IDX_W'(word_index(32'(p1_accept ? p1_addr : p1_addr_q), OFF_W));
        p2_idx_c   = IDX_W'(word_index(32'(p2_accept ? p2_addr : p2_addr_q), OFF_W));
        p2_we_c    = p2_accept ? p2_we    : p2_we_q;
        p2_wdata_c = p2_accept ? p2_wdata : p2_wdata_q;
        p1_home_c  = home_word(p1_idx_c);
        p2_home_c  = home_word(p2_idx_c);
        p1_old_c   = mem_q[p1_idx_c] ^ p1_home_c;
        p2_old_c   = mem_q[p2_idx_c] ^ p2_home_c;
        p2_wenc_c  = p2_wdata_c ^ p2_home_c;
    end

`ifdef MEM_RDW_FORWARD_EN
    logic [DATA_W-1:0] p1_merge_c;

    // Port-1 read data with a same-edge port-2 write merged lane by lane.
    always_comb begin
        p1_merge_c = p1_old_c;
        for (int k = 0; k < int'(NB); k++) begin
            if (p2_we_c[k]) begin
                p1_merge_c[8*k +: 8] = p2_wdata_c[8*k +: 8];
            end
        end
        p1_read_c = (p1_fire && p2_fire && (p1_idx_c == p2_idx_c)) ? p1_merge_c : p1_old_c;
    end
`else
    // Port-1 read data: plain read-first, ignores any same-edge write.
    always_comb begin
        p1_read_c = p1_old_c;
    end
`endif

    // Byte-lane writes on the completing edge of a port-2 access.
    always_ff @(posedge clk) begin
        if (p2_fire) begin
            for (int k = 0; k < int'(NB); k++) begin
                if (p2_we_c[k]) begin
                    mem_q[p2_idx_c][8*k +: 8] <= p2_wenc_c[8*k +: 8];
                end
            end
        end
    end

    // Read data registered on completion and held for the ready cycle only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_rdata <= '0;
            p2_rdata <= '0;
        end else begin
            p1_rdata <= p1_fire ? p1_read_c : '0;
            p2_rdata <= p2_fire ? p2_old_c  : '0;
        end
    end

endmodule

// File: tb/tb_timed_dual_port_mem.sv
// Scoreboard bench for timed_dual_port_mem: three 16-bit instances
// (LATENCY 1, 3, 4) and one 32-bit/12-bit-address instance (LATENCY 2).
module tb_timed_dual_port_mem;

    localparam int NI = 3;
    localparam int NK = 8;

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        sb [NK][$];
    logic [31:0] shadow [int];

    logic        p1_req   [NI];
    logic [15:0] p1_addr  [NI];
    logic [15:0] p1_rdata [NI];
    logic        p1_ready [NI];
    logic        p2_req   [NI];
    logic [15:0] p2_addr  [NI];
    logic [1:0]  p2_we    [NI];
    logic [15:0] p2_wdata [NI];
    logic [15:0] p2_rdata [NI];
    logic        p2_ready [NI];

    logic        w_p1_req;
    logic [11:0] w_p1_addr;
    logic [31:0] w_p1_rdata;
    logic        w_p1_ready;
    logic        w_p2_req;
    logic [11:0] w_p2_addr;
    logic [3:0]  w_p2_we;
    logic [31:0] w_p2_wdata;
    logic [31:0] w_p2_rdata;
    logic        w_p2_ready;

    logic        rdy_v [NK];
    logic [31:0] rd_v  [NK];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        timed_dual_port_mem #(
            .ADDR_W  (16),
            .DATA_W  (16),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .p1_req   (p1_req[g]),
            .p1_addr  (p1_addr[g]),
            .p1_rdata (p1_rdata[g]),
            .p1_ready (p1_ready[g]),
            .p2_req   (p2_req[g]),
            .p2_addr  (p2_addr[g]),
            .p2_we    (p2_we[g]),
            .p2_wdata (p2_wdata[g]),
            .p2_rdata (p2_rdata[g]),
            .p2_ready (p2_ready[g])
        );
    end

    timed_dual_port_mem #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .LATENCY (2)
    ) u_w (
        .clk      (clk),
        .rst      (rst),
        .p1_req   (w_p1_req),
        .p1_addr  (w_p1_addr),
        .p1_rdata (w_p1_rdata),
        .p1_ready (w_p1_ready),
        .p2_req   (w_p2_req),
        .p2_addr  (w_p2_addr),
        .p2_we    (w_p2_we),
        .p2_wdata (w_p2_wdata),
        .p2_rdata (w_p2_rdata),
        .p2_ready (w_p2_ready)
    );

    // Flatten all port outputs: slot 2*i is port 1, 2*i+1 is port 2.
    always_comb begin
        for (int g = 0; g < NI; g++) begin
            rdy_v[2*g]   = p1_ready[g];
            rd_v[2*g]    = 32'(p1_rdata[g]);
            rdy_v[2*g+1] = p2_ready[g];
            rd_v[2*g+1]  = 32'(p2_rdata[g]);
        end
        rdy_v[6] = w_p1_ready;
        rd_v[6]  = w_p1_rdata;
        rdy_v[7] = w_p2_ready;
        rd_v[7]  = w_p2_rdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int nb_of(input int i);
        return (i == 3) ? 4 : 2;
    endfunction

    function automatic int key_of(input int i, input logic [15:0] addr);
        int a = (i == 3) ? int'(addr[11:0]) : int'(addr);
        return i * 65536 + a / nb_of(i);
    endfunction

    function automatic logic [31:0] mdl_read(input int i, input logic [15:0] addr);
        int k = key_of(i, addr);
        int w = (k - i * 65536) * nb_of(i);
        if (shadow.exists(k)) return shadow[k];
        return (i == 3) ? 32'(w) : 32'(16'(w));
    endfunction

    function automatic void mdl_write(input int i, input logic [15:0] addr,
                                      input logic [3:0] we, input logic [31:0] wdata);
        logic [31:0] v = mdl_read(i, addr);
        for (int b = 0; b < nb_of(i); b++) begin
            if (we[b]) v[8*b +: 8] = wdata[8*b +: 8];
        end
        shadow[key_of(i, addr)] = v;
    endfunction

    task automatic expect_at(input int k, input int stamp, input logic [31:0] data);
        exp_t e;
        e.cyc  = stamp;
        e.data = data;
        sb[k].push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_p1(input int i, input logic [15:0] addr);
        if (i == 3) begin
            w_p1_req  = 1'b1;
            w_p1_addr = addr[11:0];
        end else begin
            p1_req[i]  = 1'b1;
            p1_addr[i] = addr;
        end
    endtask

    task automatic drive_p2(input int i, input logic [15:0] addr,
                            input logic [3:0] we, input logic [31:0] wdata);
        if (i == 3) begin
            w_p2_req   = 1'b1;
            w_p2_addr  = addr[11:0];
            w_p2_we    = we;
            w_p2_wdata = wdata;
        end else begin
            p2_req[i]   = 1'b1;
            p2_addr[i]  = addr;
            p2_we[i]    = we[1:0];
            p2_wdata[i] = wdata[15:0];
        end
    endtask

    task automatic idle_all();
        for (int g = 0; g < NI; g++) begin
            p1_req[g] = 1'b0;
            p2_req[g] = 1'b0;
        end
        w_p1_req = 1'b0;
        w_p2_req = 1'b0;
    endtask

    // Single isolated port-1 read, started from IDLE.
    task automatic op_read(input int i, input logic [15:0] addr, input logic [31:0] exp);
        expect_at(2*i, cyc + 1 + lat_of(i), exp);
        drive_p1(i, addr);
        tick(1);
        idle_all();
        tick(lat_of(i) + 1);
    endtask

    // Single isolated port-2 access, started from IDLE; returns the old word.
    task automatic op_p2(input int i, input logic [15:0] addr, input logic [3:0] we,
                         input logic [31:0] wdata, input logic [31:0] exp_old);
        expect_at(2*i + 1, cyc + 1 + lat_of(i), exp_old);
        mdl_write(i, addr, we, wdata);
        drive_p2(i, addr, we, wdata);
        tick(1);
        idle_all();
        tick(lat_of(i) + 1);
    endtask

    // Scoreboard consumer: every ready pops one expectation; idle rdata is 0.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int k = 0; k < NK; k++) begin
                if (rdy_v[k]) begin
                    check($sformatf("ready_expected[%0d]", k), 32'(sb[k].size() != 0), 32'd1);
                    if (sb[k].size() != 0) begin
                        e = sb[k].pop_front();
                        check($sformatf("rdata[%0d]", k), rd_v[k], e.data);
                        check($sformatf("ready_cycle[%0d]", k), 32'(cyc), 32'(e.cyc));
                    end
                end else begin
                    check($sformatf("idle_rdata[%0d]", k), rd_v[k], 32'd0);
                end
            end
        end
    end

    initial begin
        int          c;
        int          ri;
        int          kind;
        logic [15:0] ra;
        logic [3:0]  rwe;
        logic [31:0] rwd;

        for (int g = 0; g < NI; g++) begin
            p1_addr[g]  = '0;
            p2_addr[g]  = '0;
            p2_we[g]    = '0;
            p2_wdata[g] = '0;
        end
        w_p1_addr  = '0;
        w_p2_addr  = '0;
        w_p2_we    = '0;
        w_p2_wdata = '0;
        idle_all();

        // Reset, then quiet outputs.
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_p1_ready", 32'(p1_ready[0]), 32'd0);
        check("rst_p1_rdata", 32'(p1_rdata[0]), 32'd0);
        check("rst_p2_ready", 32'(p2_ready[1]), 32'd0);
        check("rst_w_p1_rdata", w_p1_rdata, 32'd0);

        // LATENCY 1 basic read.
        op_read(0, 16'h0010, 32'h0000_0010);

        // LATENCY 1 back-to-back: after the first, one completion per cycle
        // using the address live at each chained acceptance.
        c = cyc;
        drive_p1(0, 16'h0030);
        expect_at(0, c + 2, 32'h0030);
        expect_at(0, c + 3, 32'h0032);
        expect_at(0, c + 4, 32'h0034);
        tick(2);
        p1_addr[0] = 16'h0032;
        tick(1);
        p1_addr[0] = 16'h0034;
        tick(1);
        idle_all();
        tick(3);

        // LATENCY 3 streaming read held high; address change while BUSY.
        c = cyc;
        drive_p2(1, 16'h0100, 4'b0000, 32'h0);
        expect_at(3, c + 4,  32'h0100);
        expect_at(3, c + 7,  32'h0100);
        expect_at(3, c + 10, 32'h0100);
        tick(9);
        p2_addr[1] = 16'h0200;
        idle_all();
        tick(4);

        // Byte write returns old word; readback shows only lane 0 changed.
        op_p2(0, 16'h0040, 4'b0001, 32'h0000_ABCD, 32'h0000_0040);
        op_read(0, 16'h0041, 32'h0000_00CD);

        // Same-edge full-word conflict.
        c = cyc;
        drive_p1(0, 16'h0080);
        drive_p2(0, 16'h0080, 4'b0011, 32'h0000_1234);
`ifdef MEM_RDW_FORWARD_EN
        expect_at(0, c + 2, 32'h1234);
`else
        expect_at(0, c + 2, 32'h0080);
`endif
        expect_at(1, c + 2, 32'h0080);
        mdl_write(0, 16'h0080, 4'b0011, 32'h0000_1234);
        tick(1);
        idle_all();
        tick(2);
        op_read(0, 16'h0080, 32'h0000_1234);

        // Same-edge partial conflict: upper lane only.
        c = cyc;
        drive_p1(0, 16'h0090);
        drive_p2(0, 16'h0091, 4'b0010, 32'h0000_BEEF);
`ifdef MEM_RDW_FORWARD_EN
        expect_at(0, c + 2, 32'hBE90);
`else
        expect_at(0, c + 2, 32'h0090);
`endif
        expect_at(1, c + 2, 32'h0090);
        mdl_write(0, 16'h0090, 4'b0010, 32'h0000_BEEF);
        tick(1);
        idle_all();
        tick(2);
        op_read(0, 16'h0090, 32'h0000_BE90);

        // Reset two cycles after acceptance abandons the LATENCY 4 write.
        drive_p2(2, 16'h0020, 4'b0011, 32'h0000_5555);
        tick(1);
        idle_all();
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(6);
        op_read(2, 16'h0020, 32'h0000_0020);

        // 32-bit / 12-bit-address instance.
        op_read(3, 16'h0008, 32'h0000_0008);
        op_p2(3, 16'h0008, 4'b1000, 32'hFF00_0000, 32'h0000_0008);
        op_read(3, 16'h0008, 32'hFF00_0008);

        // LATENCY 2 chaining out of DONE: one completion every 2 cycles.
        c = cyc;
        drive_p1(3, 16'h0010);
        expect_at(6, c + 3, 32'h0000_0010);
        expect_at(6, c + 5, 32'h0000_0010);
        tick(4);
        idle_all();
        tick(3);

        // Random isolated accesses against the shadow model.
        for (int r = 0; r < 40; r++) begin
            ri   = int'($urandom_range(0, 3));
            ra   = 16'($urandom_range(0, 63));
            kind = int'($urandom_range(0, 2));
            rwe  = (ri == 3) ? 4'($urandom_range(1, 15)) : 4'($urandom_range(1, 3));
            rwd  = $urandom;
            if (kind == 0) op_read(ri, ra, mdl_read(ri, ra));
            else if (kind == 1) op_p2(ri, ra, 4'b0000, 32'h0, mdl_read(ri, ra));
            else op_p2(ri, ra, rwe, rwd, mdl_read(ri, ra));
        end

        tick(5);
        for (int k = 0; k < NK; k++) begin
            check($sformatf("sb_drain[%0d]", k), 32'(sb[k].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
